// File: rtl/uart_rx_frame.sv
// UART receive framer: synchronised SIN, oversampled start detect, 3-tick majority
// vote, 5..DW data bits, optional odd/even/stick parity, framing and break flags.
module uart_rx_frame #(
  parameter int OVERSAMPLE  = 16,
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2,
  localparam int WLW = $clog2(DW + 1)
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           RXCLK,
  input  logic           SIN,
  input  logic           CLEAR,
  input  logic [WLW-1:0] WLEN,
  input  logic           PEN,
  input  logic           EPS,
  input  logic           SP,
  output logic [DW-1:0]  DOUT,
  output logic           DVALID,
  output logic           PE,
  output logic           FE,
  output logic           BI,
  output logic           BUSY
);

  localparam int CW  = $clog2(OVERSAMPLE);
  localparam int BIW = $clog2(DW);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, MWAIT} state_t;

  state_t                 state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic [2:0]             shreg_reg;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic [BIW-1:0]         bitidx_reg, bitidx_next;
  logic [BIW-1:0]         last_idx_reg, last_idx_next;
  logic [DW-1:0]          data_reg, data_next;
  logic                   pen_reg, pen_next, eps_reg, eps_next, sp_reg, sp_next;
  logic                   par_bit_reg, par_bit_next, pe_pend_reg, pe_pend_next;
  logic [DW-1:0]          dout_reg, dout_next;
  logic                   dvalid_reg, dvalid_next;
  logic                   pe_reg, pe_next, fe_reg, fe_next, bi_reg, bi_next;

  logic           s;
  logic           vote;
  logic           half_pt, mid_pt;
  logic [WLW-1:0] wlen_eff;

  assign s       = sync_reg[SYNC_STAGES-1];
  assign vote    = (shreg_reg[0] & shreg_reg[1]) | (shreg_reg[0] & shreg_reg[2]) |
                   (shreg_reg[1] & shreg_reg[2]);
  assign half_pt = (cnt_reg == CW'(OVERSAMPLE / 2 - 1));
  assign mid_pt  = (cnt_reg == CW'(OVERSAMPLE - 1));

  always_comb begin
    if (WLEN < WLW'(5))       wlen_eff = WLW'(5);
    else if (WLEN > WLW'(DW)) wlen_eff = WLW'(DW);
    else                      wlen_eff = WLEN;
  end

  // Synchroniser always runs; the vote history only advances on RXCLK ticks.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_reg  <= '1;
      shreg_reg <= 3'b111;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], SIN};
      if (RXCLK) shreg_reg <= {shreg_reg[1:0], s};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      bitidx_reg   <= '0;
      last_idx_reg <= '0;
      data_reg     <= '0;
      pen_reg      <= 1'b0;
      eps_reg      <= 1'b0;
      sp_reg       <= 1'b0;
      par_bit_reg  <= 1'b0;
      pe_pend_reg  <= 1'b0;
      dout_reg     <= '0;
      dvalid_reg   <= 1'b0;
      pe_reg       <= 1'b0;
      fe_reg       <= 1'b0;
      bi_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      bitidx_reg   <= bitidx_next;
      last_idx_reg <= last_idx_next;
      data_reg     <= data_next;
      pen_reg      <= pen_next;
      eps_reg      <= eps_next;
      sp_reg       <= sp_next;
      par_bit_reg  <= par_bit_next;
      pe_pend_reg  <= pe_pend_next;
      dout_reg     <= dout_next;
      dvalid_reg   <= dvalid_next;
      pe_reg       <= pe_next;
      fe_reg       <= fe_next;
      bi_reg       <= bi_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    bitidx_next   = bitidx_reg;
    last_idx_next = last_idx_reg;
    data_next     = data_reg;
    pen_next      = pen_reg;
    eps_next      = eps_reg;
    sp_next       = sp_reg;
    par_bit_next  = par_bit_reg;
    pe_pend_next  = pe_pend_reg;
    dout_next     = dout_reg;
    dvalid_next   = 1'b0;
    pe_next       = pe_reg;
    fe_next       = fe_reg;
    bi_next       = bi_reg;

    if (CLEAR) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else if (RXCLK) begin
      cnt_next = cnt_reg + 1'b1;
      case (state_reg)
        IDLE: begin
          cnt_next = '0;
          if (!s) begin
            state_next    = START;
            last_idx_next = BIW'(wlen_eff - 1'b1);
            pen_next      = PEN;
            eps_next      = EPS;
            sp_next       = SP;
            data_next     = '0;
            bitidx_next   = '0;
            par_bit_next  = 1'b0;
            pe_pend_next  = 1'b0;
          end
        end
        START: if (half_pt) begin
          cnt_next   = '0;
          state_next = vote ? IDLE : DATA;
        end
        DATA: if (mid_pt) begin
          cnt_next              = '0;
          data_next[bitidx_reg] = vote;
          if (bitidx_reg == last_idx_reg) begin
            bitidx_next = '0;
            state_next  = pen_reg ? PAR : STOP;
          end else begin
            bitidx_next = bitidx_reg + 1'b1;
          end
        end
        PAR: if (mid_pt) begin
          cnt_next     = '0;
          par_bit_next = vote;
          pe_pend_next = sp_reg ? (vote != ~eps_reg)
                                : ((^data_reg) ^ vote ^ eps_reg ^ 1'b1);
          state_next   = STOP;
        end
        STOP: if (mid_pt) begin
          cnt_next    = '0;
          dout_next   = data_reg;
          pe_next     = pen_reg & pe_pend_reg;
          fe_next     = ~vote;
          bi_next     = (data_reg == '0) & (~pen_reg | ~par_bit_reg) & ~vote;
          dvalid_next = 1'b1;
          state_next  = bi_next ? MWAIT : IDLE;
        end
        MWAIT: begin
          // Break: hold off until the line returns high before hunting again.
          cnt_next = '0;
          if (s) state_next = IDLE;
        end
        default: begin
          cnt_next   = '0;
          state_next = IDLE;
        end
      endcase
    end
  end

  assign DOUT   = dout_reg;
  assign DVALID = dvalid_reg;
  assign PE     = pe_reg;
  assign FE     = fe_reg;
  assign BI     = bi_reg;
  assign BUSY   = (state_reg != IDLE);

endmodule
